// File: rtl/des_req_scheduler.sv
// des_req_scheduler: round-robin front end that shares one pipelined DES core
// among NUM_REQ requesters. Each issued block carries a {valid,id} token down a
// pipe that moves in lockstep with the core, so the result can be tagged with
// its requester on the response port. When the consumer backpressures a valid
// result, des_en drops and the core and token pipe freeze together, so no
// result is ever lost.
//
// Optional build macro DES_SCHED_PERF_EN adds the perf_clr input and the
// saturating perf_issued / perf_stall counters.
module des_req_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 18
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*64-1:0] req_plaintext,
    input  logic [NUM_REQ*64-1:0] req_key,
    input  logic                  halt,
    output logic [63:0]           des_plaintext,
    output logic [63:0]           des_key,
    output logic                  des_en,
    input  logic [63:0]           des_cyphertext,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [63:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  idle
`ifdef DES_SCHED_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_stall
`endif
);

    localparam int OCC_W = $clog2(LATENCY + 1);

    // Token pipe: entry 0 is the block sampled by the core on the last enabled
    // edge, entry LATENCY-1 lines up with des_cyphertext.
    logic [LATENCY-1:0] tok_valid;
    logic [ID_W-1:0]    tok_id [LATENCY];

    logic [ID_W-1:0]    rr_ptr;
    logic [OCC_W-1:0]   occupancy;
    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic               issue;
    logic               pop;

    // Response side is a direct view of the pipe tail and the core output.
    always_comb begin
        rsp_valid = tok_valid[LATENCY-1];
        rsp_id    = tok_id[LATENCY-1];
        rsp_data  = des_cyphertext;
        des_en    = !(tok_valid[LATENCY-1] && !rsp_ready);
        pop       = rsp_valid && rsp_ready;
        idle      = (occupancy == '0);
    end

    // Round-robin search: first asserted request at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any conditional path, so
        // this block stays purely combinational instead of inferring latches.
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        if (des_en && !halt) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!grant_any && i == idx && req_valid[i]) begin
                        grant_any = 1'b1;
                        grant_id  = ID_W'(i);
                    end
                end
            end
        end
    end

    // Drive the winner's handshake and operands to the core; bubbles carry zeros.
    always_comb begin
        req_ready     = '0;
        des_plaintext = '0;
        des_key       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_any && grant_id == ID_W'(i)) begin
                req_ready[i]  = 1'b1;
                des_plaintext = req_plaintext[i*64 +: 64];
                des_key       = req_key[i*64 +: 64];
            end
        end
        issue = grant_any;
    end

    // Token pipe shifts only on enabled edges so it tracks the frozen core.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state is only ever updated with non-blocking
            // assignments so every register samples pre-edge values.
            tok_valid <= '0;
            // NOTE: tok_id is gated by tok_valid and would not strictly need a
            // reset; clearing it keeps rsp_id deterministic after reset.
            for (int i = 0; i < LATENCY; i++) tok_id[i] <= '0;
        end else if (des_en) begin
            tok_valid <= {tok_valid[LATENCY-2:0], issue};
            tok_id[0] <= grant_id;
            for (int i = 1; i < LATENCY; i++) tok_id[i] <= tok_id[i-1];
        end
    end

    // Pointer moves past the winner only when a handshake actually completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
        end
    end

    // In-flight block count: +1 per issue, -1 per popped response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef DES_SCHED_PERF_EN
    // Saturating event counters for accepted blocks and stalled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else if (perf_clr) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
            if (!des_en && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_des_req_scheduler.sv
// Bench for des_req_scheduler: a behavioural pipelined DES core stands in for
// the real one (known vectors by lookup, a keyed mix otherwise) and a
// transaction-level scoreboard predicts grants, response timing and data.
module tb_des_req_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int LATENCY = 18;

    logic                  clk;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*64-1:0] req_plaintext;
    logic [NUM_REQ*64-1:0] req_key;
    logic                  halt;
    logic [63:0]           des_plaintext;
    logic [63:0]           des_key;
    logic                  des_en;
    logic [63:0]           des_cyphertext;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [63:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  idle;
`ifdef DES_SCHED_PERF_EN
    logic                  perf_clr;
    logic [31:0]           perf_issued;
    logic [31:0]           perf_stall;
    assign perf_clr = 1'b0;
`endif

    des_req_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_plaintext(req_plaintext), .req_key(req_key), .halt(halt),
        .des_plaintext(des_plaintext), .des_key(des_key), .des_en(des_en),
        .des_cyphertext(des_cyphertext),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .idle(idle)
`ifdef DES_SCHED_PERF_EN
        , .perf_clr(perf_clr), .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural core: known DES vectors by lookup, a keyed mix otherwise.
    function automatic logic [63:0] cipher_fn(input logic [63:0] pt, input logic [63:0] key);
        case ({key, pt})
            {64'h133457799BBCDFF1, 64'h0123456789ABCDEF}: return 64'h85E813540F0AB405;
            {64'h0000000000000000, 64'h0000000000000000}: return 64'h8CA64DE9C1B123A7;
            {64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA}: return 64'hC4322BE19E9A5A17;
            {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF}: return 64'h7359B2163E4EDC58;
            default: return pt ^ {key[31:0], key[63:32]} ^ 64'hC3A50F1E7D29B486;
        endcase
    endfunction

    logic [63:0] core_stage [LATENCY];
    always @(posedge clk) begin
        if (des_en) begin
            core_stage[0] <= cipher_fn(des_plaintext, des_key);
            for (int i = 1; i < LATENCY; i++) core_stage[i] <= core_stage[i-1];
        end
    end
    assign des_cyphertext = core_stage[LATENCY-1];

    typedef struct packed { logic [63:0] pt; logic [63:0] key; } blk_t;
    typedef struct { int id; logic [63:0] data; longint e0; } sb_t;
    typedef struct { int id; logic [63:0] data; int cyc; } rsp_t;
    typedef struct { int id; int cyc; } gnt_t;
    typedef struct { logic [63:0] key; logic [63:0] pt; logic [63:0] exp; } vec_t;

    blk_t   req_q [NUM_REQ][$];   // per-requester pending blocks, front is presented
    sb_t    sb_q [$];             // in-flight blocks in issue order
    rsp_t   rsp_log [$];
    gnt_t   grant_log [$];
    int     rr;
    longint en_edges;
    int     cyc;
    int     tests;
    int     fails;

    task automatic check(input string name, input bit ok, input string detail);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NUM_REQ; i++) if (req_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic apply_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_q[i].size() > 0) begin
                req_valid[i]             = 1'b1;
                req_plaintext[i*64 +: 64] = req_q[i][0].pt;
                req_key[i*64 +: 64]       = req_q[i][0].key;
            end else begin
                req_valid[i]             = 1'b0;
                req_plaintext[i*64 +: 64] = '0;
                req_key[i*64 +: 64]       = '0;
            end
        end
    endtask

    // One clock: predict this cycle's outputs, compare, then advance the model
    // across the coming rising edge. Called just after a falling edge.
    task automatic tick();
        bit                 exp_v, exp_en, exp_idle;
        int                 g;
        int                 idx;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [63:0]        exp_pt, exp_key, exp_data;
        int                 exp_id;
        bit                 ok;
        apply_inputs();
        #1;
        exp_v    = sb_q.size() > 0 && (en_edges - sb_q[0].e0 == LATENCY);
        exp_en   = !(exp_v && !rsp_ready);
        exp_idle = sb_q.size() == 0;
        exp_data = exp_v ? sb_q[0].data : '0;
        exp_id   = exp_v ? sb_q[0].id : 0;
        g = -1;
        if (exp_en && !halt) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (rr + k) % NUM_REQ;
                if (g < 0 && req_q[idx].size() > 0) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? NUM_REQ'(1) << g : '0;
        exp_pt  = (g >= 0) ? req_q[g][0].pt  : '0;
        exp_key = (g >= 0) ? req_q[g][0].key : '0;
        ok = rsp_valid === exp_v && des_en === exp_en && req_ready === exp_rdy &&
             des_plaintext === exp_pt && des_key === exp_key && idle === exp_idle;
        if (exp_v) ok = ok && rsp_data === exp_data && rsp_id === ID_W'(exp_id);
        check("cycle", ok, $sformatf(
            "cyc %0d got v=%0b en=%0b rdy=%b pt=%h id=%0d data=%h idle=%0b, want v=%0b en=%0b rdy=%b pt=%h id=%0d data=%h idle=%0b",
            cyc, rsp_valid, des_en, req_ready, des_plaintext, rsp_id, rsp_data, idle,
            exp_v, exp_en, exp_rdy, exp_pt, exp_id, exp_data, exp_idle));
        if (exp_v && rsp_ready) begin
            rsp_log.push_back('{id: int'(rsp_id), data: rsp_data, cyc: cyc});
            void'(sb_q.pop_front());
        end
        if (g >= 0) begin
            sb_q.push_back('{id: g, data: cipher_fn(exp_pt, exp_key), e0: en_edges});
            grant_log.push_back('{id: g, cyc: cyc});
            void'(req_q[g].pop_front());
            rr = (g + 1) % NUM_REQ;
        end
        if (exp_en) en_edges++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || pending()) && n < budget) begin
            tick();
            n++;
        end
        check("drain_bound", n < budget, $sformatf("cycles used %0d, allowed below %0d", n, budget));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < NUM_REQ; i++) req_q[i].delete();
        halt      = 1'b0;
        rsp_ready = 1'b1;
        apply_inputs();
        reset_n = 1'b0;
        sb_q.delete();
        rr = 0;
        repeat (n) begin
            #1;
            check("reset_state", rsp_valid === 1'b0 && idle === 1'b1 && req_ready === '0 && des_en === 1'b1,
                  $sformatf("got v=%0b idle=%0b rdy=%b en=%0b, want v=0 idle=1 rdy=0000 en=1",
                            rsp_valid, idle, req_ready, des_en));
            @(negedge clk);
        end
        reset_n = 1'b1;
    endtask

    function automatic blk_t rand_blk();
        return '{pt: {$urandom, $urandom}, key: {$urandom, $urandom}};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [3];
        logic [63:0] bp_exp [$];
        int          base_r, base_g, n;
        blk_t        b;

        vecs[0] = '{key: 64'h0, pt: 64'h0, exp: 64'h8CA64DE9C1B123A7};
        vecs[1] = '{key: 64'hAAAAAAAAAAAAAAAA, pt: 64'hAAAAAAAAAAAAAAAA, exp: 64'hC4322BE19E9A5A17};
        vecs[2] = '{key: 64'hFFFFFFFFFFFFFFFF, pt: 64'hFFFFFFFFFFFFFFFF, exp: 64'h7359B2163E4EDC58};

        tests = 0; fails = 0; cyc = 0; en_edges = 0; rr = 0;
        req_valid = '0; req_plaintext = '0; req_key = '0;
        halt = 1'b0; rsp_ready = 1'b1;
        do_reset(3);

        // Round robin: all four requesters hold valid from a fresh pointer.
        base_g = grant_log.size(); base_r = rsp_log.size();
        for (int i = 0; i < NUM_REQ; i++) repeat (4) req_q[i].push_back(rand_blk());
        drain(200);
        for (int i = 0; i < 16; i++) begin
            if (grant_log.size() < base_g + 16 || rsp_log.size() < base_r + 16)
                check("rr_order", 1'b0, $sformatf("got %0d grants %0d rsps, want 16 each",
                      grant_log.size() - base_g, rsp_log.size() - base_r));
            else
                check("rr_order", grant_log[base_g+i].id == i % NUM_REQ &&
                      grant_log[base_g+i].cyc == grant_log[base_g].cyc + i &&
                      rsp_log[base_r+i].id == i % NUM_REQ,
                      $sformatf("slot %0d got grant %0d at +%0d rsp id %0d, want %0d at +%0d",
                                i, grant_log[base_g+i].id, grant_log[base_g+i].cyc - grant_log[base_g].cyc,
                                rsp_log[base_r+i].id, i % NUM_REQ, i));
        end

        // Single block and its exact latency.
        base_g = grant_log.size(); base_r = rsp_log.size();
        req_q[0].push_back('{pt: 64'h0123456789ABCDEF, key: 64'h133457799BBCDFF1});
        drain(100);
        if (rsp_log.size() != base_r + 1 || grant_log.size() != base_g + 1)
            check("single", 1'b0, $sformatf("got %0d responses, want 1", rsp_log.size() - base_r));
        else
            check("single", rsp_log[base_r].data == 64'h85E813540F0AB405 && rsp_log[base_r].id == 0 &&
                  rsp_log[base_r].cyc - grant_log[base_g].cyc == LATENCY,
                  $sformatf("got data %h id %0d latency %0d, want 85e813540f0ab405 id 0 latency %0d",
                            rsp_log[base_r].data, rsp_log[base_r].id,
                            rsp_log[base_r].cyc - grant_log[base_g].cyc, LATENCY));

        // Known vectors back-to-back on requester 1.
        base_r = rsp_log.size();
        for (int i = 0; i < 3; i++) req_q[1].push_back('{pt: vecs[i].pt, key: vecs[i].key});
        drain(100);
        for (int i = 0; i < 3; i++) begin
            if (rsp_log.size() < base_r + 3)
                check("known_vec", 1'b0, $sformatf("got %0d responses, want 3", rsp_log.size() - base_r));
            else
                check("known_vec", rsp_log[base_r+i].data == vecs[i].exp && rsp_log[base_r+i].id == 1,
                      $sformatf("vec %0d got %h id %0d, want %h id 1",
                                i, rsp_log[base_r+i].data, rsp_log[base_r+i].id, vecs[i].exp));
        end

        // Backpressure: fill the pipe, hold rsp_ready low, then release.
        base_g = grant_log.size(); base_r = rsp_log.size();
        rsp_ready = 1'b0;
        bp_exp.delete();
        for (int i = 0; i < 20; i++) begin
            b = rand_blk();
            req_q[2].push_back(b);
            bp_exp.push_back(cipher_fn(b.pt, b.key));
        end
        repeat (LATENCY) tick();
        check("bp_issued", grant_log.size() - base_g == LATENCY,
              $sformatf("got %0d issued, want %0d", grant_log.size() - base_g, LATENCY));
        repeat (20) begin
            apply_inputs();
            #1;
            check("bp_stall", des_en === 1'b0 && req_ready === '0 && rsp_valid === 1'b1 && rsp_data === bp_exp[0],
                  $sformatf("got en=%0b rdy=%b v=%0b data=%h, want en=0 rdy=0000 v=1 data=%h",
                            des_en, req_ready, rsp_valid, rsp_data, bp_exp[0]));
            tick();
        end
        rsp_ready = 1'b1;
        drain(200);
        for (int i = 0; i < 20; i++) begin
            if (rsp_log.size() != base_r + 20)
                check("bp_order", 1'b0, $sformatf("got %0d responses, want 20", rsp_log.size() - base_r));
            else
                check("bp_order", rsp_log[base_r+i].data == bp_exp[i] && rsp_log[base_r+i].id == 2,
                      $sformatf("rsp %0d got %h id %0d, want %h id 2",
                                i, rsp_log[base_r+i].data, rsp_log[base_r+i].id, bp_exp[i]));
        end

        // Halt with five blocks in flight: no new grants, pipe drains to idle.
        base_g = grant_log.size(); base_r = rsp_log.size();
        repeat (10) req_q[3].push_back(rand_blk());
        repeat (5) tick();
        halt = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        #1;
        check("halt_drain", n < 60 && grant_log.size() - base_g == 5 && rsp_log.size() - base_r == 5 && idle === 1'b1,
              $sformatf("got issued %0d rsps %0d idle %0b cycles %0d, want 5 5 1 under 60",
                        grant_log.size() - base_g, rsp_log.size() - base_r, idle, n));
        @(negedge clk);
        req_q[3].delete();
        halt = 1'b0;

        // Reset with ten blocks in flight: nothing stale may come out.
        repeat (12) req_q[0].push_back(rand_blk());
        repeat (10) tick();
        do_reset(2);
        base_r = rsp_log.size();
        repeat (40) tick();
        check("reset_no_stale", rsp_log.size() == base_r,
              $sformatf("got %0d responses after reset, want 0", rsp_log.size() - base_r));

        // Random traffic against the scoreboard.
        repeat (3000) begin
            for (int i = 0; i < NUM_REQ; i++)
                if ($urandom_range(0, 3) == 0 && req_q[i].size() < 3) req_q[i].push_back(rand_blk());
            rsp_ready = ($urandom_range(0, 3) != 0);
            halt      = ($urandom_range(0, 15) == 0);
            tick();
        end
        halt = 1'b0;
        rsp_ready = 1'b1;
        drain(400);
        #1;
        check("final_idle", idle === 1'b1, $sformatf("got idle %0b, want 1", idle));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
